// File: rtl/llr_ram_pkg.sv
// Shared types and helpers for the LDPC variable-node message store.
// Contents: phase FSM state enum, default geometry, circulant address mapping.
package llr_ram_pkg;

    // Default geometry: message width, circulant size, RAM depth
    localparam int unsigned LLR_DW    = 4;
    localparam int unsigned LLR_Z     = 32;
    localparam int unsigned LLR_DEPTH = 256;

    // Load/run phase of the message store
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } llr_state_e;

    // Map a logical address to its physical word: rotate the in-block offset by
    // shift, modulo z. Caller guarantees shift < z.
    function automatic int unsigned circ_addr(input int unsigned addr,
                                              input int unsigned shift,
                                              input int unsigned z);
        int unsigned blk;
        int unsigned off;
        int unsigned sum;
        blk = addr / z;
        off = addr % z;
        sum = off + shift;
        if (sum >= z) begin
            sum = sum - z;
        end
        return blk * z + sum;
    endfunction

endpackage

// File: rtl/dp_ram_wf.sv
// Behavioural true-dual-port RAM, write-first per port, 1-cycle read latency.
// Ports (x = a/b): clk_i; en_x_i port enable; we_x_i write enable;
//   addr_x_i word address; din_x_i write data; dout_x_o read data (write-first).
// Cross-port read-during-write returns the old contents. Contents are not reset.
module dp_ram_wf #(
    parameter  int unsigned DW    = 4,
    parameter  int unsigned DEPTH = 256,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_a_i,
    input  logic          we_a_i,
    input  logic [AW-1:0] addr_a_i,
    input  logic [DW-1:0] din_a_i,
    output logic [DW-1:0] dout_a_o,
    input  logic          en_b_i,
    input  logic          we_b_i,
    input  logic [AW-1:0] addr_b_i,
    input  logic [DW-1:0] din_b_i,
    output logic [DW-1:0] dout_b_o
);

    logic [DW-1:0] mem [DEPTH];

    // Single process for both ports; port A is applied last so it wins a
    // same-address double write (the controller already prevents this).
    always_ff @(posedge clk_i) begin
        if (en_b_i) begin
            if (we_b_i) begin
                mem[addr_b_i] <= din_b_i;
                dout_b_o      <= din_b_i;
            end else begin
                dout_b_o      <= mem[addr_b_i];
            end
        end
        if (en_a_i) begin
            if (we_a_i) begin
                mem[addr_a_i] <= din_a_i;
                dout_a_o      <= din_a_i;
            end else begin
                dout_a_o      <= mem[addr_a_i];
            end
        end
    end

endmodule

// File: rtl/llr_ram_ctrl_p.sv
// Variable-node message store for the LDPC decoder.
// Wraps dp_ram_wf with a load/run phase FSM, read-valid tracking, circulant
// addressing on the VFU path and cross-port write collision arbitration.
// Ports:
//   sys_clk, sys_rst_n          clock, synchronous active-low reset
//   flag_first_store            start a new codeword load
//   org_addr/org_data/org_wr_en initial LLR write (LOAD only, port A)
//   vfu_*                       VFU access, logical address rotated by cyclic_shift (port A)
//   cfu_*                       CFU access, physical address (port B)
//   q_a_data/q_a_vld            port A read data / valid
//   q_b_data/q_b_vld            port B read data / valid
//   load_done                   high while in RUN
//   collision                   pulse: a port B write lost to port A
//   shift_err                   pulse: VFU access dropped, cyclic_shift >= Z
// Build option: define LLR_RAM_FWD_EN to forward the other port's write data
// on a same-address cross-port read-during-write.
module llr_ram_ctrl_p
    import llr_ram_pkg::*;
#(
    parameter  int unsigned DW    = LLR_DW,
    parameter  int unsigned Z     = LLR_Z,
    parameter  int unsigned DEPTH = LLR_DEPTH,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned SW    = $clog2(Z)
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          flag_first_store,
    input  logic [AW-1:0] org_addr,
    input  logic [DW-1:0] org_data,
    input  logic          org_wr_en,
    input  logic [AW-1:0] vfu_addr,
    input  logic [DW-1:0] vfu_data,
    input  logic          vfu_wr_en,
    input  logic          vfu_rd_en,
    input  logic [SW-1:0] cyclic_shift,
    input  logic [AW-1:0] cfu_addr,
    input  logic [DW-1:0] cfu_data,
    input  logic          cfu_wr_en,
    input  logic          cfu_rd_en,
    output logic [DW-1:0] q_a_data,
    output logic          q_a_vld,
    output logic [DW-1:0] q_b_data,
    output logic          q_b_vld,
    output logic          load_done,
    output logic          collision,
    output logic          shift_err
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    llr_state_e    state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          load_done_q;

    // Port A / port B requests after phase gating and arbitration
    logic          a_en, a_we, a_rd;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic          b_en, b_we, b_rd;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_din;
    logic [AW-1:0] vfu_phys;
    logic          shift_bad;
    logic          collision_d, shift_err_d;

    logic [DW-1:0] ram_qa, ram_qb;
    logic [DW-1:0] sel_qa, sel_qb;
    logic          a_vld_q, b_vld_q;
    logic [DW-1:0] a_hold_q, b_hold_q;
    logic          collision_q, shift_err_q;

    // Phase FSM: state and load counter register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            load_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            load_done_q <= (state_d == ST_RUN);
        end
    end

    // Phase FSM: next state; the load count only restarts on entry to LOAD
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            ST_IDLE: begin
                if (flag_first_store) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            end
            ST_LOAD: begin
                if (org_wr_en) begin
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(DEPTH - 1)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (flag_first_store) begin
                    state_d = ST_LOAD;
                    count_d = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    assign vfu_phys  = AW'(circ_addr(32'(vfu_addr), 32'(cyclic_shift), Z));
    assign shift_bad = (32'(cyclic_shift) >= Z);

    // Port steering by phase, shift check and port-A-wins write arbitration
    always_comb begin
        a_en        = 1'b0;
        a_we        = 1'b0;
        a_rd        = 1'b0;
        a_addr      = '0;
        a_din       = '0;
        b_en        = 1'b0;
        b_we        = 1'b0;
        b_rd        = 1'b0;
        b_addr      = '0;
        b_din       = '0;
        collision_d = 1'b0;
        shift_err_d = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (org_wr_en) begin
                    a_en   = 1'b1;
                    a_we   = 1'b1;
                    a_addr = org_addr;
                    a_din  = org_data;
                end
            end
            ST_RUN: begin
                if (vfu_rd_en || vfu_wr_en) begin
                    if (shift_bad) begin
                        shift_err_d = 1'b1;
                    end else begin
                        a_en   = 1'b1;
                        a_we   = vfu_wr_en;
                        a_rd   = vfu_rd_en;
                        a_addr = vfu_phys;
                        a_din  = vfu_data;
                    end
                end
                if (cfu_rd_en || cfu_wr_en) begin
                    b_rd   = cfu_rd_en;
                    b_we   = cfu_wr_en;
                    b_addr = cfu_addr;
                    b_din  = cfu_data;
                    if (cfu_wr_en && a_we && (a_addr == cfu_addr)) begin
                        b_we        = 1'b0;
                        collision_d = 1'b1;
                    end
                    b_en = b_rd || b_we;
                end
            end
            default: ;
        endcase
    end

    dp_ram_wf #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk_i    (sys_clk),
        .en_a_i   (a_en),
        .we_a_i   (a_we),
        .addr_a_i (a_addr),
        .din_a_i  (a_din),
        .dout_a_o (ram_qa),
        .en_b_i   (b_en),
        .we_b_i   (b_we),
        .addr_b_i (b_addr),
        .din_b_i  (b_din),
        .dout_b_o (ram_qb)
    );

`ifdef LLR_RAM_FWD_EN
    logic          fwd_a_q, fwd_b_q;
    logic [DW-1:0] fwd_a_data_q, fwd_b_data_q;

    // Capture the other port's write data on a same-address read-during-write
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            fwd_a_q      <= 1'b0;
            fwd_b_q      <= 1'b0;
            fwd_a_data_q <= '0;
            fwd_b_data_q <= '0;
        end else begin
            fwd_a_q      <= a_rd && !a_we && b_we && (a_addr == b_addr);
            fwd_b_q      <= b_rd && !b_we && a_we && (a_addr == b_addr);
            fwd_a_data_q <= b_din;
            fwd_b_data_q <= a_din;
        end
    end

    assign sel_qa = fwd_a_q ? fwd_a_data_q : ram_qa;
    assign sel_qb = fwd_b_q ? fwd_b_data_q : ram_qb;
`else
    assign sel_qa = ram_qa;
    assign sel_qb = ram_qb;
`endif

    // Read-valid tracking, output hold and error pulses
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            a_vld_q     <= 1'b0;
            b_vld_q     <= 1'b0;
            a_hold_q    <= '0;
            b_hold_q    <= '0;
            collision_q <= 1'b0;
            shift_err_q <= 1'b0;
        end else begin
            a_vld_q     <= a_rd;
            b_vld_q     <= b_rd;
            a_hold_q    <= q_a_data;
            b_hold_q    <= q_b_data;
            collision_q <= collision_d;
            shift_err_q <= shift_err_d;
        end
    end

    // RAM output is only trusted in the cycle after a read; otherwise hold
    assign q_a_data  = a_vld_q ? sel_qa : a_hold_q;
    assign q_b_data  = b_vld_q ? sel_qb : b_hold_q;
    assign q_a_vld   = a_vld_q;
    assign q_b_vld   = b_vld_q;
    assign load_done = load_done_q;
    assign collision = collision_q;
    assign shift_err = shift_err_q;

endmodule

// File: tb/tb_llr_ram_ctrl_p.sv
// Directed bench for llr_ram_ctrl_p: default geometry instance (Z=32, DEPTH=256)
// plus a Z=24, DEPTH=48 instance for the out-of-range shift case.
module tb_llr_ram_ctrl_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Default instance signals
    logic       rst_n = 1'b0;
    logic       flag = 1'b0;
    logic [7:0] org_addr = '0;
    logic [3:0] org_data = '0;
    logic       org_wr_en = 1'b0;
    logic [7:0] vfu_addr = '0;
    logic [3:0] vfu_data = '0;
    logic       vfu_wr_en = 1'b0, vfu_rd_en = 1'b0;
    logic [4:0] shift = '0;
    logic [7:0] cfu_addr = '0;
    logic [3:0] cfu_data = '0;
    logic       cfu_wr_en = 1'b0, cfu_rd_en = 1'b0;
    logic [3:0] q_a_data, q_b_data;
    logic       q_a_vld, q_b_vld, load_done, collision, shift_err;

    // Z=24 instance signals
    logic       s_rst_n = 1'b0;
    logic       s_flag = 1'b0;
    logic [5:0] s_org_addr = '0;
    logic [3:0] s_org_data = '0;
    logic       s_org_wr_en = 1'b0;
    logic [5:0] s_vfu_addr = '0;
    logic [3:0] s_vfu_data = '0;
    logic       s_vfu_wr_en = 1'b0, s_vfu_rd_en = 1'b0;
    logic [4:0] s_shift = '0;
    logic [5:0] s_cfu_addr = '0;
    logic [3:0] s_cfu_data = '0;
    logic       s_cfu_wr_en = 1'b0, s_cfu_rd_en = 1'b0;
    logic [3:0] s_q_a_data, s_q_b_data;
    logic       s_q_a_vld, s_q_b_vld, s_load_done, s_collision, s_shift_err;

    llr_ram_ctrl_p u_dut (
        .sys_clk(clk), .sys_rst_n(rst_n), .flag_first_store(flag),
        .org_addr(org_addr), .org_data(org_data), .org_wr_en(org_wr_en),
        .vfu_addr(vfu_addr), .vfu_data(vfu_data), .vfu_wr_en(vfu_wr_en),
        .vfu_rd_en(vfu_rd_en), .cyclic_shift(shift),
        .cfu_addr(cfu_addr), .cfu_data(cfu_data), .cfu_wr_en(cfu_wr_en),
        .cfu_rd_en(cfu_rd_en),
        .q_a_data(q_a_data), .q_a_vld(q_a_vld), .q_b_data(q_b_data),
        .q_b_vld(q_b_vld), .load_done(load_done), .collision(collision),
        .shift_err(shift_err)
    );

    llr_ram_ctrl_p #(.DW(4), .Z(24), .DEPTH(48)) u_dut24 (
        .sys_clk(clk), .sys_rst_n(s_rst_n), .flag_first_store(s_flag),
        .org_addr(s_org_addr), .org_data(s_org_data), .org_wr_en(s_org_wr_en),
        .vfu_addr(s_vfu_addr), .vfu_data(s_vfu_data), .vfu_wr_en(s_vfu_wr_en),
        .vfu_rd_en(s_vfu_rd_en), .cyclic_shift(s_shift),
        .cfu_addr(s_cfu_addr), .cfu_data(s_cfu_data), .cfu_wr_en(s_cfu_wr_en),
        .cfu_rd_en(s_cfu_rd_en),
        .q_a_data(s_q_a_data), .q_a_vld(s_q_a_vld), .q_b_data(s_q_b_data),
        .q_b_vld(s_q_b_vld), .load_done(s_load_done), .collision(s_collision),
        .shift_err(s_shift_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1 ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) begin
            org_addr  = 8'(i);
            org_data  = 4'(i);
            org_wr_en = 1'b1;
            tick();
        end
        org_wr_en = 1'b0;
    endtask

    task automatic cfu_read(input logic [7:0] a);
        cfu_addr  = a;
        cfu_rd_en = 1'b1;
        tick();
        cfu_rd_en = 1'b0;
    endtask

    task automatic vfu_read(input logic [7:0] a, input logic [4:0] sh);
        vfu_addr  = a;
        shift     = sh;
        vfu_rd_en = 1'b1;
        tick();
        vfu_rd_en = 1'b0;
    endtask

    task automatic vfu_write(input logic [7:0] a, input logic [4:0] sh, input logic [3:0] d);
        vfu_addr  = a;
        shift     = sh;
        vfu_data  = d;
        vfu_wr_en = 1'b1;
        tick();
        vfu_wr_en = 1'b0;
    endtask

    initial begin
        logic [3:0] exp_fwd;

        // Reset state
        tick(); tick();
        check("rst_q_a_data", 32'(q_a_data), 0);
        check("rst_q_b_data", 32'(q_b_data), 0);
        check("rst_q_a_vld", 32'(q_a_vld), 0);
        check("rst_q_b_vld", 32'(q_b_vld), 0);
        check("rst_load_done", 32'(load_done), 0);
        check("rst_collision", 32'(collision), 0);
        check("rst_shift_err", 32'(shift_err), 0);
        rst_n = 1'b1;

        // IDLE ignores reads
        cfu_read(8'd37);
        check("idle_no_vld", 32'(q_b_vld), 0);

        // Full load
        flag = 1'b1; tick(); flag = 1'b0;
        load_words(255);
        check("load_255_not_done", 32'(load_done), 0);
        org_addr = 8'd255; org_data = 4'd15; org_wr_en = 1'b1;
        tick();
        org_wr_en = 1'b0;
        check("load_done_rise", 32'(load_done), 1);

        // CFU read, latency 1 then hold
        cfu_read(8'd37);
        check("cfu_rd37_vld", 32'(q_b_vld), 1);
        check("cfu_rd37_data", 32'(q_b_data), 5);
        tick();
        check("cfu_vld_drop", 32'(q_b_vld), 0);
        check("cfu_data_hold", 32'(q_b_data), 5);

        // Circulant rotation on VFU reads
        vfu_read(8'd70, 5'd30);
        check("rot30_vld", 32'(q_a_vld), 1);
        check("rot30_data", 32'(q_a_data), 4);
        vfu_read(8'd70, 5'd26);
        check("rot26_data", 32'(q_a_data), 0);

        // Rotated write: logical 33 (blk1 off1) shift 5 -> phys 38
        vfu_write(8'd33, 5'd5, 4'd13);
        check("vfu_wr_no_vld", 32'(q_a_vld), 0);
        check("vfu_wr_hold", 32'(q_a_data), 0);
        cfu_read(8'd38);
        check("rot_wr_phys38", 32'(q_b_data), 13);
        cfu_read(8'd33);
        check("rot_wr_log33_untouched", 32'(q_b_data), 1);

        // Collision: both write phys 10, port A wins
        vfu_addr = 8'd10; shift = 5'd0; vfu_data = 4'd3; vfu_wr_en = 1'b1;
        cfu_addr = 8'd10; cfu_data = 4'd9; cfu_wr_en = 1'b1;
        tick();
        vfu_wr_en = 1'b0; cfu_wr_en = 1'b0;
        check("collision_pulse", 32'(collision), 1);
        tick();
        check("collision_clear", 32'(collision), 0);
        cfu_read(8'd10);
        check("collision_winner", 32'(q_b_data), 3);

        // Same-port read+write is write-first
        vfu_addr = 8'd20; shift = 5'd0; vfu_data = 4'd11;
        vfu_wr_en = 1'b1; vfu_rd_en = 1'b1;
        tick();
        vfu_wr_en = 1'b0; vfu_rd_en = 1'b0;
        check("wf_vld", 32'(q_a_vld), 1);
        check("wf_data", 32'(q_a_data), 11);

        // Cross-port read-during-write at phys 12
        vfu_write(8'd12, 5'd0, 4'd2);
        vfu_addr = 8'd12; shift = 5'd0; vfu_rd_en = 1'b1;
        cfu_addr = 8'd12; cfu_data = 4'd7; cfu_wr_en = 1'b1;
        tick();
        vfu_rd_en = 1'b0; cfu_wr_en = 1'b0;
`ifdef LLR_RAM_FWD_EN
        exp_fwd = 4'd7;
`else
        exp_fwd = 4'd2;
`endif
        check("xport_rdw_a", 32'(q_a_data), 32'(exp_fwd));
        check("xport_no_collision", 32'(collision), 0);
        vfu_read(8'd12, 5'd0);
        check("xport_after", 32'(q_a_data), 7);

        // org writes ignored in RUN
        org_addr = 8'd0; org_data = 4'd15; org_wr_en = 1'b1;
        tick();
        org_wr_en = 1'b0;
        cfu_read(8'd0);
        check("run_org_ignored", 32'(q_b_data), 0);

        // RUN -> LOAD; requests ignored in LOAD
        flag = 1'b1; tick(); flag = 1'b0;
        check("reload_done_low", 32'(load_done), 0);
        vfu_read(8'd5, 5'd0);
        check("load_vfu_no_vld", 32'(q_a_vld), 0);
        load_words(100);

        // Reset mid-LOAD then full reload with flag held high throughout
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        check("midload_rst_done", 32'(load_done), 0);
        flag = 1'b1; tick();
        load_words(255);
        check("reload_255_not_done", 32'(load_done), 0);
        org_addr = 8'd255; org_data = 4'd15; org_wr_en = 1'b1;
        tick();
        org_wr_en = 1'b0; flag = 1'b0;
        check("reload_done", 32'(load_done), 1);

        // Reset with a read requested discards it
        rst_n = 1'b0; cfu_addr = 8'd37; cfu_rd_en = 1'b1;
        tick();
        cfu_rd_en = 1'b0;
        check("rst_read_no_vld", 32'(q_b_vld), 0);
        check("rst_read_data", 32'(q_b_data), 0);
        check("rst_run_done", 32'(load_done), 0);
        rst_n = 1'b1;

        // Z=24 instance: load 48 words with data = addr[3:0]
        s_rst_n = 1'b1;
        s_flag = 1'b1; tick(); s_flag = 1'b0;
        for (int i = 0; i < 48; i++) begin
            s_org_addr = 6'(i); s_org_data = 4'(i); s_org_wr_en = 1'b1;
            tick();
        end
        s_org_wr_en = 1'b0;
        check("z24_load_done", 32'(s_load_done), 1);

        // Valid rotation: logical 30 (blk1 off6) shift 20 -> phys 26
        s_vfu_addr = 6'd30; s_shift = 5'd20; s_vfu_rd_en = 1'b1;
        tick();
        s_vfu_rd_en = 1'b0;
        check("z24_rot_data", 32'(s_q_a_data), 10);
        check("z24_rot_no_err", 32'(s_shift_err), 0);

        // shift 25 >= Z: write dropped
        s_vfu_addr = 6'd5; s_shift = 5'd25; s_vfu_data = 4'd9; s_vfu_wr_en = 1'b1;
        tick();
        s_vfu_wr_en = 1'b0;
        check("z24_shift_err", 32'(s_shift_err), 1);
        tick();
        check("z24_shift_err_clear", 32'(s_shift_err), 0);
        s_cfu_addr = 6'd5; s_cfu_rd_en = 1'b1; tick(); s_cfu_rd_en = 1'b0;
        check("z24_ram5_unchanged", 32'(s_q_b_data), 5);
        s_cfu_addr = 6'd6; s_cfu_rd_en = 1'b1; tick(); s_cfu_rd_en = 1'b0;
        check("z24_ram6_unchanged", 32'(s_q_b_data), 6);

        // Out-of-range shift on a read gives no valid
        s_vfu_addr = 6'd5; s_shift = 5'd24; s_vfu_rd_en = 1'b1;
        tick();
        s_vfu_rd_en = 1'b0;
        check("z24_bad_rd_no_vld", 32'(s_q_a_vld), 0);
        check("z24_bad_rd_err", 32'(s_shift_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
